// File: rtl/com_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// com_pkg
// Shared definitions for the com1 serial path (receiver now; the transmitter
// and the com1 command block will reuse the clock/baud constants).
//   rx_state_t         receiver state encoding
//   CLK_HZ, BAUD       system clock and line rate
//   CLKS_PER_BIT_DFLT  default clocks per bit (12 MHz / 115200, truncated)
//   even_parity()      XOR-reduction of a byte (used when the parity build
//                      option UART_RX_PARITY_EN is defined)
// -----------------------------------------------------------------------------
package com_pkg;

  localparam int CLK_HZ            = 12_000_000;
  localparam int BAUD              = 115_200;
  localparam int CLKS_PER_BIT_DFLT = CLK_HZ / BAUD;  // 104

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage : com_pkg

// File: rtl/uart_rx_8n1_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_rx_8n1_if
// Groups the serial line and the byte-stream outputs of the receiver.
//   RX          raw serial input, idle high, asynchronous to the clock
//   DATA[7:0]   last correctly received byte
//   VALID       one-cycle strobe, DATA is new in the same cycle
//   FRAME_ERR   one-cycle strobe, stop bit sampled low
//   BUSY        high while a frame is being received
//   PARITY_ERR  one-cycle strobe, only when UART_RX_PARITY_EN is defined
// Modports:
//   slave   the receiver (drives the byte-stream outputs)
//   master  the environment (drives RX, consumes the byte stream)
// -----------------------------------------------------------------------------
interface uart_rx_8n1_if;

  logic       RX;
  logic [7:0] DATA;
  logic       VALID;
  logic       FRAME_ERR;
  logic       BUSY;
`ifdef UART_RX_PARITY_EN
  logic       PARITY_ERR;
`endif

  modport slave (
    input  RX,
    output DATA, VALID, FRAME_ERR, BUSY
`ifdef UART_RX_PARITY_EN
    , output PARITY_ERR
`endif
  );

  modport master (
    output RX,
    input  DATA, VALID, FRAME_ERR, BUSY
`ifdef UART_RX_PARITY_EN
    , input PARITY_ERR
`endif
  );

endinterface : uart_rx_8n1_if

// File: rtl/uart_rx_8n1_sync_vote.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// rx_sync_vote
// Input conditioning for the UART receiver: a 2-flop synchronizer followed by
// a 3-sample history with a majority vote, plus a falling-edge flag on the
// synchronized line. Every flop presets to 1 (the idle line level), so a line
// that is already low when reset releases shows up as a falling edge.
//   clk, rst_n   clock, asynchronous active-low reset
//   rx_i         raw serial input (asynchronous)
//   rx_sync_o    synchronized line level
//   vote_o       majority of the last three synchronized samples
//   fall_o       synchronized line went 1 -> 0 this cycle
// -----------------------------------------------------------------------------
module rx_sync_vote (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_i,
  output logic rx_sync_o,
  output logic vote_o,
  output logic fall_o
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic [2:0] hist_q,  hist_d;

  // NOTE: give every signal written in always_comb a value first; a path that
  // leaves one unassigned infers a latch.
  always_comb begin
    sync1_d = rx_i;
    sync2_d = sync1_q;
    hist_d  = {hist_q[1:0], sync2_q};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: reset presets to the idle level 1, not 0; a 0 here would look
      // like a start bit right after reset.
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 3'b111;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
    end
  end

  assign rx_sync_o = sync2_q;
  assign vote_o    = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) |
                     (hist_q[1] & hist_q[2]);
  // hist_q[0] holds last cycle's synchronized level.
  assign fall_o    = hist_q[0] & ~sync2_q;

endmodule : rx_sync_vote

// File: rtl/uart_rx_8n1.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_rx_8n1
// 8N1 serial receiver feeding the com1 command parser. Bytes arrive LSB first;
// each bit is the majority vote of three synchronized samples taken around the
// middle of the bit. Start-bit glitches are rejected at mid-start, a low stop
// bit raises FRAME_ERR and the receiver then waits for the line to go high
// before it looks for a new start edge.
// Build option: define UART_RX_PARITY_EN for 8E1 frames (a PARITY state between
// DATA and STOP and a PARITY_ERR strobe on the interface).
// Parameters:
//   CLKS_PER_BIT  clock cycles per bit, at least 8
//   HALF_BIT      start-edge to mid-bit offset
// Ports:
//   CLK    system clock (12 MHz)
//   RST_N  asynchronous active-low reset
//   bus    uart_rx_8n1_if.slave: RX in; DATA, VALID, FRAME_ERR, BUSY
//          (and PARITY_ERR) out
// -----------------------------------------------------------------------------
module uart_rx_8n1
  import com_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DFLT,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic           CLK,
  input  logic           RST_N,
  uart_rx_8n1_if.slave   bus
);

  localparam int             CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  HALF_CNT = CW'(HALF_BIT);
  localparam logic [CW-1:0]  LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic rx_sync;
  logic rx_vote;
  logic rx_fall;

  rx_sync_vote u_sync_vote (
    .clk       (CLK),
    .rst_n     (RST_N),
    .rx_i      (bus.RX),
    .rx_sync_o (rx_sync),
    .vote_o    (rx_vote),
    .fall_o    (rx_fall)
  );

  rx_state_t     state_q,     state_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic [2:0]    bit_idx_q,   bit_idx_d;
  logic [7:0]    shift_q,     shift_d;
  logic [7:0]    data_q,      data_d;
  logic          valid_q,     valid_d;
  logic          frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic          par_bit_q,    par_bit_d;
  logic          parity_err_q, parity_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d    = par_bit_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (rx_fall) begin
          cnt_d   = '0;
          state_d = START;
        end
      end

      START: begin
        if (cnt_q == HALF_CNT) begin
          if (!rx_vote) begin
            // Start bit confirmed at mid-bit; from here every sample is a
            // full bit period apart, i.e. also at mid-bit.
            cnt_d     = '0;
            bit_idx_d = '0;
            state_d   = DATA;
          end else begin
            state_d = IDLE;  // glitch, no strobe
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DATA: begin
        if (cnt_q == LAST_CNT) begin
          shift_d[bit_idx_q] = rx_vote;
          cnt_d              = '0;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == LAST_CNT) begin
          par_bit_d = rx_vote;
          cnt_d     = '0;
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif

      STOP: begin
        if (cnt_q == LAST_CNT) begin
          // Leaving at mid-stop leaves half a bit to find the next start
          // edge, so back-to-back frames with one stop bit are not missed.
          if (rx_vote) begin
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            if (even_parity(shift_q) ^ par_bit_q) begin
              parity_err_d = 1'b1;
            end else begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
`else
            data_d  = shift_q;
            valid_d = 1'b1;
`endif
          end else begin
            // Framing error wins over a parity error.
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      BREAK: begin
        // A line held low must not be read as a string of start bits.
        if (rx_sync) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign bus.DATA      = data_q;
  assign bus.VALID     = valid_q;
  assign bus.FRAME_ERR = frame_err_q;
  assign bus.BUSY      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.PARITY_ERR = parity_err_q;
`endif

endmodule : uart_rx_8n1

// File: tb/tb_uart_rx_8n1.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_rx_8n1
// Drives real-time serial frames (8680.555 ns/bit) into uart_rx_8n1 on a
// 12 MHz clock. The bench keeps a queue of the outcomes each sent frame must
// produce (good byte, framing error, parity error) and the byte DATA must hold;
// one process compares every strobe and DATA against that model on each
// falling clock edge. Directed checks pin reset values, latency, glitch
// rejection, break handling and mid-frame reset.
// Define UART_RX_PARITY_EN to build and test the 8E1 variant.
// -----------------------------------------------------------------------------
module tb_uart_rx_8n1;

  localparam real HALF_CLK   = 41.6667;
  localparam real CLK_PERIOD = 2.0 * HALF_CLK;
  localparam real BIT_NS     = 8680.555;
  localparam int  CPB        = 104;
  localparam int  HALF       = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int  EXP_LAT    = 2 + HALF + 10 * CPB + 2;
`else
  localparam int  EXP_LAT    = 2 + HALF + 9 * CPB + 2;
`endif

  localparam int EV_VALID = 0;
  localparam int EV_FERR  = 1;
  localparam int EV_PERR  = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;

  logic CLK;
  logic RST_N;

  uart_rx_8n1_if u_if ();

  uart_rx_8n1 #(.CLKS_PER_BIT(CPB)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (u_if)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  ev_t        exp_q[$];
  logic [7:0] model_data = 8'h00;
  int         n_valid = 0;
  int         n_ferr  = 0;
  int         n_perr  = 0;
  int         n_busy_rise = 0;
  realtime    t_fall  = 0.0;
  realtime    t_valid = 0.0;
  logic       prev_valid = 1'b0;
  logic       prev_ferr  = 1'b0;
  logic       prev_busy  = 1'b0;

  initial begin
    CLK = 1'b0;
    forever #(HALF_CLK) CLK = ~CLK;
  end

  initial begin
    #(5_000_000.0);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_rng(input string nm, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] d);
    ev_t e;
    e.kind = kind;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic take_ev(input int kind, input string nm);
    ev_t e;
    check({nm, "_pending"}, exp_q.size() != 0, 1'b1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({nm, "_kind"}, e.kind, kind);
      if (kind == EV_VALID) begin
        check({nm, "_data"}, u_if.DATA, e.data);
        model_data = e.data;
      end
    end
  endtask

  // Compare process: strobes against the expected-outcome queue, DATA against
  // the last good byte, strobe exclusivity and single-cycle width.
  always @(negedge CLK) begin
    int nstb;
    if (!RST_N) begin
      prev_valid = 1'b0;
      prev_ferr  = 1'b0;
      prev_busy  = 1'b0;
    end else begin
      nstb = int'(u_if.VALID) + int'(u_if.FRAME_ERR);
`ifdef UART_RX_PARITY_EN
      nstb += int'(u_if.PARITY_ERR);
      if (u_if.PARITY_ERR) begin
        n_perr++;
        take_ev(EV_PERR, "perr");
      end
`endif
      if (nstb != 0) check("strobe_exclusive", nstb, 1);
      if (u_if.VALID) begin
        check("valid_width", prev_valid, 1'b0);
        n_valid++;
        t_valid = $realtime;
        take_ev(EV_VALID, "valid");
      end else begin
        check("data_hold", u_if.DATA, model_data);
      end
      if (u_if.FRAME_ERR) begin
        check("ferr_width", prev_ferr, 1'b0);
        n_ferr++;
        take_ev(EV_FERR, "ferr");
      end
      if (u_if.BUSY && !prev_busy) n_busy_rise++;
      prev_valid = u_if.VALID;
      prev_ferr  = u_if.FRAME_ERR;
      prev_busy  = u_if.BUSY;
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_val);
    u_if.RX = 1'b0;
    t_fall  = $realtime;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      u_if.RX = b[i];
      #(BIT_NS);
    end
`ifdef UART_RX_PARITY_EN
    u_if.RX = ^b;
    #(BIT_NS);
`endif
    u_if.RX = stop_val;
    #(BIT_NS);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] b, input logic par);
    u_if.RX = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      u_if.RX = b[i];
      #(BIT_NS);
    end
    u_if.RX = par;
    #(BIT_NS);
    u_if.RX = 1'b1;
    #(BIT_NS);
  endtask
`endif

  task automatic wait_drain(input string nm, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge CLK);
    @(negedge CLK);
    check(nm, exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0] msg [5];
    int         v0, f0, r0, lat;
    logic       saw_busy, busy_cleared;

    msg = '{8'h53, 8'h30, 8'h45, 8'h36, 8'h0A};
    u_if.RX = 1'b1;
    RST_N   = 1'b0;
    repeat (4) @(negedge CLK);
    check("rst_data",  u_if.DATA,      8'h00);
    check("rst_valid", u_if.VALID,     1'b0);
    check("rst_ferr",  u_if.FRAME_ERR, 1'b0);
    check("rst_busy",  u_if.BUSY,      1'b0);
`ifdef UART_RX_PARITY_EN
    check("rst_perr",  u_if.PARITY_ERR, 1'b0);
`endif
    RST_N = 1'b1;
    repeat (10) @(negedge CLK);

    // 1: single 0x53 frame, plus first-byte latency.
    expect_ev(EV_VALID, 8'h53);
    send_frame(8'h53, 1'b1);
    wait_drain("t1_drain", 200);
    check("t1_data", u_if.DATA, 8'h53);
    lat = int'((t_valid - t_fall) / CLK_PERIOD);
    check_rng("t1_latency", lat, EXP_LAT - 1, EXP_LAT + 1);
    #(BIT_NS);

    // 2: back-to-back "S0E6\n", single stop bits.
    v0 = n_valid;
    r0 = n_busy_rise;
    foreach (msg[i]) expect_ev(EV_VALID, msg[i]);
    foreach (msg[i]) send_frame(msg[i], 1'b1);
    wait_drain("t2_drain", 200);
    check("t2_valid_count", n_valid - v0, 5);
    check("t2_busy_rises", n_busy_rise - r0, 5);
    check("t2_data", u_if.DATA, 8'h0A);
    check("t2_busy_idle", u_if.BUSY, 1'b0);
    #(BIT_NS);

    // 3: 2 us glitch on the idle line.
    v0 = n_valid;
    f0 = n_ferr;
    saw_busy     = 1'b0;
    busy_cleared = 1'b0;
    @(negedge CLK);
    u_if.RX = 1'b0;
    fork
      begin
        #(2000.0);
        u_if.RX = 1'b1;
      end
    join_none
    for (int i = 0; i < HALF + 4 && !busy_cleared; i++) begin
      @(negedge CLK);
      if (u_if.BUSY) saw_busy = 1'b1;
      else if (saw_busy) busy_cleared = 1'b1;
    end
    check("t3_busy_seen", saw_busy, 1'b1);
    check("t3_busy_cleared", busy_cleared, 1'b1);
    #(2.0 * BIT_NS);
    @(negedge CLK);
    check("t3_no_valid", n_valid - v0, 0);
    check("t3_no_ferr", n_ferr - f0, 0);

    // 4: 0x44 with a low stop bit, line held low, then 0x34.
    f0 = n_ferr;
    v0 = n_valid;
    expect_ev(EV_FERR, 8'h00);
    send_frame(8'h44, 1'b0);
    #(25_000.0);
    @(negedge CLK);
    check("t4_busy_in_break", u_if.BUSY, 1'b1);
    #(25_000.0);
    wait_drain("t4_drain", 10);
    check("t4_ferr_count", n_ferr - f0, 1);
    check("t4_no_valid", n_valid - v0, 0);
    check("t4_data_kept", u_if.DATA, 8'h0A);
    u_if.RX = 1'b1;
    repeat (8) @(negedge CLK);
    check("t4_busy_after_rise", u_if.BUSY, 1'b0);
    #(BIT_NS);
    expect_ev(EV_VALID, 8'h34);
    send_frame(8'h34, 1'b1);
    wait_drain("t4b_drain", 200);
    check("t4_data_new", u_if.DATA, 8'h34);
    #(BIT_NS);

    // 5: reset in the middle of 0x30 (during bit 4), then 0x36.
    v0 = n_valid;
    u_if.RX = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      u_if.RX = msg[1][i];
      #(BIT_NS);
    end
    u_if.RX = msg[1][4];
    #(BIT_NS / 2.0);
    @(negedge CLK);
    check("t5_busy_mid", u_if.BUSY, 1'b1);
    #(10.0);
    RST_N = 1'b0;
    #(1.0);
    check("t5_async_busy", u_if.BUSY, 1'b0);
    check("t5_async_data", u_if.DATA, 8'h00);
    check("t5_async_valid", u_if.VALID, 1'b0);
    exp_q.delete();
    model_data = 8'h00;
    u_if.RX = 1'b1;
    repeat (4) @(negedge CLK);
    RST_N = 1'b1;
    #(BIT_NS);
    check("t5_no_valid", n_valid - v0, 0);
    expect_ev(EV_VALID, 8'h36);
    send_frame(8'h36, 1'b1);
    wait_drain("t5_drain", 200);
    check("t5_data", u_if.DATA, 8'h36);
    #(BIT_NS);

`ifdef UART_RX_PARITY_EN
    // 6: 0x53 with correct even parity, then with the parity bit flipped.
    v0 = n_valid;
    expect_ev(EV_VALID, 8'h53);
    send_frame_par(8'h53, 1'b0);
    expect_ev(EV_PERR, 8'h00);
    send_frame_par(8'h53, 1'b1);
    wait_drain("t6_drain", 200);
    check("t6_valid_count", n_valid - v0, 1);
    check("t6_perr_count", n_perr, 1);
    check("t6_data", u_if.DATA, 8'h53);
`endif

    repeat (20) @(negedge CLK);
    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_uart_rx_8n1

// File: doc/uart_rx_8n1.md
Name: uart_rx_8n1

Overview:
- Serial receiver that sits directly upstream of the com1 command block.
- Recovers 8N1 bytes (LSB first) from the asynchronous RX pin at 115200 baud on the 12 MHz CLK.
- Presents each byte with a one-cycle VALID strobe to the command parser, which consumes the ASCII command stream ("S0E6\n" etc.).
- Flags framing errors and rejects start-bit glitches.

Parameters:
- CLKS_PER_BIT, 104: CLK cycles per bit (12 MHz / 115200, truncated); must be at least 8.
- HALF_BIT, CLKS_PER_BIT/2: offset from the start-bit falling edge to the mid-bit sample point.

Ports:
- CLK  in  1  system clock, 12 MHz
- RST_N  in  1  asynchronous active-low reset
- RX  in  1  raw serial input; idle high; asynchronous to CLK
- DATA  out  8  last correctly received byte
- VALID  out  1  one-cycle strobe; DATA is new in the same cycle
- FRAME_ERR  out  1  one-cycle strobe; stop bit sampled low
- BUSY  out  1  high while a frame is being received (state is not IDLE)

Behaviour:
- Reset: one clock (CLK); reset is asynchronous and active-low (RST_N). When asserted, all state clears immediately regardless of CLK.
- Reset values: DATA=8'h00, VALID=0, FRAME_ERR=0, BUSY=0, state=IDLE. Synchronizer flops and vote history preset to 1, the idle level.
- Input path: 2-flop synchronizer, then a 3-deep history shift register. Bit value = majority of the 3 history bits.
- Counters: cycle counter cnt (width clog2(CLKS_PER_BIT)); bit index 0..7; 8-bit shift register filled LSB first.
- IDLE: the synchronized RX moves from 1 to 0 -> cnt=0, go to START.
- START: when cnt==HALF_BIT, take the vote.
  - Vote 0: cnt=0, bit index=0, go to DATA.
  - Vote 1: the edge was a glitch; return to IDLE with no strobe.
- DATA: when cnt==CLKS_PER_BIT-1, take the vote and shift it into bit[index], then cnt=0.
  - After index 7 go to STOP (or PARITY when the feature is enabled).
- STOP: when cnt==CLKS_PER_BIT-1, take the vote.
  - Vote 1: DATA<=shift register, VALID=1 on the next cycle, go to IDLE. Returning at mid-stop allows back-to-back frames with a single stop bit.
  - Vote 0: FRAME_ERR=1 for one cycle, DATA unchanged, go to BREAK.
- BREAK: wait until the synchronized RX is 1, then go to IDLE. A line held low is never read as repeated start bits.
- Latency: VALID rises about 2 + HALF_BIT + 9*CLKS_PER_BIT + 2 CLK cycles after the RX falling edge, and is deterministic for a given phase.
- VALID and FRAME_ERR never assert in the same cycle, and neither lasts more than one cycle.
- DATA holds its value until the next good frame.
- Reset mid-frame: the partial byte is discarded, no strobe is produced, and reception restarts from IDLE.
- RX low when reset releases: treated as a start edge, because the synchronizer preset is 1.
- Baud tolerance: with 104 clocks/bit and mid-bit sampling, the design accepts at least ±2% rate error over a frame.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1. A PARITY state is inserted between DATA and STOP.
  - The parity bit is sampled like a data bit.
  - Adds output PARITY_ERR (1 bit, one-cycle strobe, reset 0), raised when the XOR of the 8 data bits and the parity bit is 1.
  - A parity-error frame pulses PARITY_ERR, does not assert VALID, and leaves DATA unchanged.
  - Frame error takes priority: only FRAME_ERR pulses if both errors occur.
- Undefined: no PARITY state and no PARITY_ERR port; plain 8N1.

Decomposition:
- Package com_pkg:
  - rx_state_t enum: IDLE, START, DATA, PARITY, STOP, BREAK.
  - Constants CLK_HZ=12000000, BAUD=115200 and default CLKS_PER_BIT=104, shared with the future transmitter and com1.
- Sub-module rx_sync_vote: 2-flop synchronizer, 3-sample history and majority output, plus a fall-edge flag. Reset preset is 1.
- The state machine and counters stay in uart_rx_8n1.

Test Plan:
1. Frame 0x53 at 8680.555 ns/bit (start 0; bits 1,1,0,0,1,0,1,0; stop 1) -> one VALID pulse, DATA=8'h53, FRAME_ERR stays 0.
2. Back-to-back "S0E6\n" (0x53,0x30,0x45,0x36,0x0A), each with a single stop bit -> exactly 5 VALID pulses in order, none missed, BUSY low only between frames.
3. 2 µs low pulse on idle RX -> no VALID, no FRAME_ERR, BUSY returns to 0 within HALF_BIT+4 cycles.
4. Frame 0x44 with stop bit driven 0, then RX held low for 50 µs -> single FRAME_ERR pulse, DATA keeps its previous value, no further strobes until RX rises; a following 0x34 frame then gives DATA=8'h34.
5. RST_N asserted mid-byte (after bit 3 of 0x30) -> outputs reset immediately, no VALID for that frame; the next 0x36 frame is received correctly.
6. With UART_RX_PARITY_EN: 0x53 with parity 0 -> VALID, DATA=8'h53; 0x53 with parity 1 -> PARITY_ERR pulse, no VALID.
